// File: rtl/pipeline_pkg.sv
// Shared definitions for the 3-stage RV32I pipeline: data widths, the NOP encoding
// and the fetch entry that pairs a PC with its instruction word.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of tagged fetch entries between imem responses and the IF/ID register.
// Head is read combinationally so a pop can load IF/ID in the same cycle.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wr_data,
  output fetch_entry_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // The fetch credit rule keeps pushes away from a full buffer.
      assert (!(push && full && !pop));
      assert (!(pop && empty));
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: PC generation, credit-limited imem requests,
// drop-after-redirect, response bypass/buffering. Optional counters under FETCH_PERF_EN.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   resp_pc_reg;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_empty, fifo_full;
  fetch_entry_t  fifo_head, rsp_entry;
  logic          req_fire, rsp_drop, rsp_tagged;
  logic          advance, fifo_pop, fifo_push, bypass;
  logic [1:0]    unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Slots are shared between in-flight requests and buffered words, so a response always has room.
  assign credit_used    = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && !fifo_full
                          && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = imem_rsp_valid && (drop_cnt_reg != '0);
  assign rsp_tagged = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
  assign rsp_entry  = {resp_pc_reg, imem_rsp_data};

  assign advance   = !redirect_valid && !stall_if_id;
  assign fifo_pop  = advance && !fifo_empty;
  assign bypass    = advance && fifo_empty && rsp_tagged;
  assign fifo_push = rsp_tagged && !bypass;

  always_comb begin
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    if (req_fire)       outstanding_next = outstanding_next + CW'(1);
    if (imem_rsp_valid) outstanding_next = outstanding_next - CW'(1);
    // A response arriving with the redirect is discarded directly, not counted.
    if (redirect_valid)
      drop_cnt_next = outstanding_reg - (imem_rsp_valid ? CW'(1) : CW'(0));
    else if (rsp_drop)
      drop_cnt_next = drop_cnt_reg - CW'(1);
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (redirect_valid),
    .wr_data (rsp_entry),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      if_id_valid     <= 1'b0;
      if_id_pc        <= '0;
      if_id_instr     <= NOP_INSTR;
    end else begin
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      if (redirect_valid) begin
        fetch_pc_reg <= word_align(redirect_pc);
        resp_pc_reg  <= word_align(redirect_pc);
        if_id_valid  <= 1'b0;
        if_id_pc     <= '0;
        if_id_instr  <= NOP_INSTR;
      end else begin
        if (req_fire)   fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (rsp_tagged) resp_pc_reg  <= resp_pc_reg + 32'd4;
        if (advance) begin
          if (fifo_pop) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= fifo_head.pc;
            if_id_instr <= fifo_head.instr;
          end else if (bypass) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= rsp_entry.pc;
            if_id_instr <= rsp_entry.instr;
          end else begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
          end
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fifo_pop || bypass)             perf_fetched <= perf_fetched + 32'd1;
      if (stall_if_id && !redirect_valid) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an in-order imem model with variable latency and a
// queue-based reference of the fetch stream, plus a second instance for PC wrap.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int N_CYC = 2130;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if_id, redirect_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, if_id_valid;
  logic [31:0] imem_req_addr, if_id_pc, if_id_instr;

  logic        r2_rsp_valid, r2_req_valid, r2_if_id_valid;
  logic [31:0] r2_rsp_data, r2_req_addr, r2_if_id_pc, r2_if_id_instr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_if_id(stall_if_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .stall_if_id(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_req_valid(r2_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(r2_req_addr), .imem_rsp_valid(r2_rsp_valid), .imem_rsp_data(r2_rsp_data),
    .if_id_valid(r2_if_id_valid), .if_id_pc(r2_if_id_pc), .if_id_instr(r2_if_id_instr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // imem model: in-order queue of (address, earliest response cycle)
  logic [31:0] memq_addr[$];
  int          memq_due[$];
  // reference: tagged words waiting to enter IF/ID, in program order
  logic [31:0] pend_pc[$];
  logic [31:0] pend_instr[$];

  logic [31:0] m_fetch_pc, m_resp_pc, exp_pc, exp_instr, rsp_a, tgt;
  logic        exp_valid, exp_rv, hs, rsp_v, stall, redir, ready;
  int          m_drop, n_inflight, lat_cfg, lat;
  logic        watch_100;
  logic        hs2_prev;
  logic [31:0] hs2_addr_prev, exp2_addr, exp2_pc;
  int          n2_addr, n2_pc;

  initial begin
    rst = 1'b0;
    stall_if_id = 0; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; r2_rsp_valid = 0; r2_rsp_data = 0;
    m_fetch_pc = 0; m_resp_pc = 0; m_drop = 0;
    exp_valid = 0; exp_pc = 0; exp_instr = NOP;
    watch_100 = 0; hs2_prev = 0; hs2_addr_prev = 0;
    exp2_addr = 32'hFFFF_FFF8; exp2_pc = 32'hFFFF_FFF8; n2_addr = 0; n2_pc = 0;
    #2 rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_id_valid", 32'(if_id_valid), 32'd0);
    chk("rst_if_id_pc", if_id_pc, 32'h0);
    chk("rst_if_id_instr", if_id_instr, NOP);
    chk("rst_wrap_req_addr", r2_req_addr, 32'hFFFF_FFF8);

    for (cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      if (cyc == 0) rst = 1'b0;

      stall = 0; redir = 0; tgt = 0; ready = 1; lat_cfg = 0;
      if (cyc >= 20 && cyc <= 22) stall = 1;
      if (cyc >= 40 && cyc < 50) lat_cfg = 3;
      if (cyc == 50) begin redir = 1; tgt = 32'h0000_0100; end
      if (cyc == 70) begin redir = 1; stall = 1; tgt = 32'h0000_0202; end
      if (cyc >= 90 && cyc < 2090) begin
        stall   = ($urandom_range(0, 99) < 20);
        redir   = ($urandom_range(0, 99) < 5);
        tgt     = $urandom;
        ready   = ($urandom_range(0, 99) < 70);
        lat_cfg = -1;
      end

      n_inflight = memq_addr.size();
      rsp_v = 0; rsp_a = 0;
      if (n_inflight > 0 && memq_due[0] <= cyc) begin
        rsp_v = 1;
        rsp_a = memq_addr.pop_front();
        void'(memq_due.pop_front());
      end

      stall_if_id    = stall;
      redirect_valid = redir;
      redirect_pc    = tgt;
      imem_req_ready = ready;
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_v ? mem_word(rsp_a) : $urandom;
      r2_rsp_valid   = hs2_prev;
      r2_rsp_data    = mem_word(hs2_addr_prev);
      #1;

      // reference-model comparisons
      chk("if_id_valid", 32'(if_id_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("if_id_pc", if_id_pc, exp_pc);
        chk("if_id_instr", if_id_instr, exp_instr);
      end else begin
        chk("bubble_instr", if_id_instr, NOP);
      end
      exp_rv = !redir && ((n_inflight + pend_pc.size()) < 2);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);

      // hand-computed pins of the directed scenarios
      if (cyc == 0) chk("first_req_addr", imem_req_addr, 32'h0);
      if (cyc <= 1) chk("startup_bubble", 32'(if_id_valid), 32'd0);
      if (cyc >= 2 && cyc <= 4) begin
        chk("startup_valid", 32'(if_id_valid), 32'd1);
        chk("startup_pc", if_id_pc, 32'((cyc - 2) * 4));
      end
      if (cyc == 21 || cyc == 22) chk("stall_req_drop", 32'(imem_req_valid), 32'd0);
      if (cyc == 51) begin
        chk("redir_addr", imem_req_addr, 32'h0000_0100);
        chk("redir_bubble", 32'(if_id_valid), 32'd0);
      end
      if (cyc > 51 && watch_100 && if_id_valid) begin
        chk("redir_first_pc", if_id_pc, 32'h0000_0100);
        watch_100 = 0;
      end
      if (cyc == 69) chk("redir_first_seen", 32'(watch_100), 32'd0);
      if (cyc == 71) begin
        chk("redir_stall_addr", imem_req_addr, 32'h0000_0200);
        chk("redir_stall_bubble", 32'(if_id_valid), 32'd0);
      end
      if (cyc == 50) watch_100 = 1;

      // wrap instance: addresses and IF/ID PCs across 2^32
      if (r2_req_valid && n2_addr < 4) begin
        chk("wrap_req_addr", r2_req_addr, exp2_addr);
        exp2_addr = exp2_addr + 32'd4;
        n2_addr++;
      end
      if (r2_if_id_valid && n2_pc < 4) begin
        chk("wrap_if_id_pc", r2_if_id_pc, exp2_pc);
        chk("wrap_if_id_instr", r2_if_id_instr, mem_word(exp2_pc));
        exp2_pc = exp2_pc + 32'd4;
        n2_pc++;
      end
      hs2_prev      = r2_req_valid;
      hs2_addr_prev = r2_req_addr;

      // imem model accepts the request seen on the bus
      hs = imem_req_valid && ready;
      if (hs) begin
        lat = (lat_cfg < 0) ? $urandom_range(0, 5) : lat_cfg;
        memq_addr.push_back(imem_req_addr);
        memq_due.push_back(cyc + 1 + lat);
      end

      // reference model of the fetch stream
      if (redir) begin
        m_drop = n_inflight - (rsp_v ? 1 : 0);
        pend_pc.delete();
        pend_instr.delete();
        m_fetch_pc = {tgt[31:2], 2'b00};
        m_resp_pc  = {tgt[31:2], 2'b00};
        exp_valid = 0; exp_pc = 0; exp_instr = NOP;
      end else begin
        if (hs) m_fetch_pc = m_fetch_pc + 32'd4;
        if (rsp_v) begin
          if (m_drop > 0) m_drop--;
          else begin
            pend_pc.push_back(m_resp_pc);
            pend_instr.push_back(mem_word(rsp_a));
            m_resp_pc = m_resp_pc + 32'd4;
          end
        end
        if (!stall) begin
          if (pend_pc.size() > 0) begin
            exp_valid = 1;
            exp_pc    = pend_pc.pop_front();
            exp_instr = pend_instr.pop_front();
          end else begin
            exp_valid = 0; exp_pc = 0; exp_instr = NOP;
          end
        end
      end
    end

    chk("wrap_addr_count", 32'(n2_addr), 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
